// File: rtl/data_mem_arbiter_if.sv
// Request/response bundle between the two requesters (CPU LSU, debug loader)
// and the data memory arbiter. Index 0 is the CPU port, index 1 the debug port.
interface data_mem_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 4
);
    logic [1:0]         req_valid;
    logic [1:0]         req_we;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][DW-1:0] req_wdata;
    logic [1:0]         req_ready;
    logic [1:0]         rsp_valid;
    logic [1:0][DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the 16x4 data memory.
// Serialises single-word requests onto the memory interface, absorbs the
// memory's one-cycle registered read latency and returns one response per
// accepted request. Clears the memory once after every reset.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | first cycle after reset release, memory clear pulse
// IDLE  | waiting for a request, ready given to the arbitration winner
// ISSUE | one-cycle memory read or write strobe from the accepted command
// WAIT  | read data arriving from the memory, captured for the response
// RESP  | one-cycle response pulse to the granted port
module data_mem_arbiter #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic              clk,
    input  logic              reset,
    data_mem_arbiter_if.slave bus,
    output logic [AW-1:0]     mem_address,
    output logic [DW-1:0]     mem_write_data,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    output logic              mem_clear,
    input  logic [DW-1:0]     mem_read_data,
    output logic              busy
);

    typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic          last_grant;
    logic          lat_port;
    logic          lat_we;
    logic          win;
    logic          any_valid;
    logic [1:0]    rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;

    // Arbitration: a lone requester wins; on contention the port not served last wins.
    always_comb begin
        any_valid = |bus.req_valid;
        if (&bus.req_valid) begin
            win = ~last_grant;
        end else begin
            win = bus.req_valid[1];
        end
    end

    assign bus.req_ready    = (state == IDLE && any_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata[0] = rsp_valid_q[0] ? rsp_rdata_q : '0;
    assign bus.rsp_rdata[1] = rsp_valid_q[1] ? rsp_rdata_q : '0;

    // The reset state is INIT, so these two decodes are gated with reset to
    // keep them low while reset is held and let the clear pulse appear only
    // in the cycle after release.
    assign mem_clear = reset && (state == INIT);
    assign busy      = reset && (state != IDLE);

    // Sequencer with registered memory strobes and response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= INIT;
            last_grant       <= 1'b1;
            lat_port         <= 1'b0;
            lat_we           <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
            rsp_valid_q      <= 2'b00;
            rsp_rdata_q      <= '0;
        end else begin
            case (state)
                INIT: begin
                    state <= IDLE;
                end
                IDLE: begin
                    if (any_valid) begin
                        lat_port         <= win;
                        lat_we           <= bus.req_we[win];
                        last_grant       <= win;
                        mem_address      <= bus.req_addr[win];
                        mem_write_data   <= bus.req_wdata[win];
                        mem_write_enable <= bus.req_we[win];
                        mem_read_enable  <= ~bus.req_we[win];
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_address      <= '0;
                    mem_write_data   <= '0;
                    mem_write_enable <= 1'b0;
                    mem_read_enable  <= 1'b0;
                    if (lat_we) begin
                        rsp_valid_q <= {lat_port, ~lat_port};
                        rsp_rdata_q <= '0;
                        state       <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    rsp_valid_q <= {lat_port, ~lat_port};
                    rsp_rdata_q <= mem_read_data;
                    state       <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= 2'b00;
                    rsp_rdata_q <= '0;
                    state       <= IDLE;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed reset/arbitration sequences, a table of
// single requests with fixed expected data, and randomized two-port traffic
// checked every cycle against a timing/memory reference model.
module tb_data_mem_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] mem_address;
    logic [3:0] mem_write_data;
    logic       mem_write_enable;
    logic       mem_read_enable;
    logic       mem_clear;
    logic [3:0] mem_read_data;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    data_mem_arbiter_if #(.AW(4), .DW(4)) bus ();

    data_mem_arbiter #(.AW(4), .DW(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_clear        (mem_clear),
        .mem_read_data    (mem_read_data),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the 16x4 data memory: synchronous clear, registered read.
    logic [3:0] mem_arr [16];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) mem_arr[i] <= 4'h0;
            mem_read_data <= 4'h0;
        end else begin
            if (mem_write_enable) mem_arr[mem_address] <= mem_write_data;
            if (mem_read_enable) mem_read_data <= mem_arr[mem_address];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (checked every cycle) ----------------
    logic [3:0]       ref_mem [16];
    bit               m_prev_rst = 1'b0;
    bit               m_last     = 1'b1;
    int               m_free     = 0;
    bit               m_pend     = 1'b0;
    int               m_pend_cyc = 0;
    int               m_pend_port = 0;
    logic [3:0]       m_pend_data = 4'h0;
    int               m_iss      = -10;
    bit               m_iss_we   = 1'b0;
    logic [3:0]       m_iss_addr = 4'h0;
    logic [3:0]       m_iss_wd   = 4'h0;
    logic [1:0]       e_ready;
    logic [1:0]       e_rspv;
    logic [1:0][3:0]  e_rd;
    bit               m_idle;
    int               g;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_rdata", bus.rsp_rdata, 0);
            chk("rst_flags", {mem_write_enable, mem_read_enable, mem_clear, busy}, 0);
            chk("rst_mem_bus", {mem_address, mem_write_data}, 0);
            m_pend = 1'b0;
            m_last = 1'b1;
            m_iss  = -10;
        end else if (!m_prev_rst) begin
            chk("init_ready", bus.req_ready, 0);
            chk("init_rsp_valid", bus.rsp_valid, 0);
            chk("init_flags", {mem_write_enable, mem_read_enable, mem_clear, busy}, 4'b0011);
            chk("init_mem_bus", {mem_address, mem_write_data}, 0);
            for (int i = 0; i < 16; i++) ref_mem[i] = 4'h0;
            m_free = cyc + 1;
        end else begin
            e_rspv = 2'b00;
            e_rd   = '0;
            if (m_pend && cyc == m_pend_cyc) begin
                e_rspv[m_pend_port] = 1'b1;
                e_rd[m_pend_port]   = m_pend_data;
                m_pend = 1'b0;
            end
            if (cyc == m_iss) begin
                chk("m_issue_we", mem_write_enable, m_iss_we);
                chk("m_issue_re", mem_read_enable, !m_iss_we);
                chk("m_issue_addr", mem_address, m_iss_addr);
                if (m_iss_we) chk("m_issue_wdata", mem_write_data, m_iss_wd);
            end else begin
                chk("m_quiet_en", {mem_write_enable, mem_read_enable}, 0);
                chk("m_quiet_bus", {mem_address, mem_write_data}, 0);
            end
            m_idle  = (cyc >= m_free);
            e_ready = 2'b00;
            if (m_idle && bus.req_valid != 2'b00) begin
                g = (bus.req_valid == 2'b11) ? int'(!m_last) : int'(bus.req_valid[1]);
                e_ready[g]  = 1'b1;
                m_last      = g[0];
                m_iss       = cyc + 1;
                m_iss_we    = bus.req_we[g];
                m_iss_addr  = bus.req_addr[g];
                m_iss_wd    = bus.req_wdata[g];
                m_pend      = 1'b1;
                m_pend_port = g;
                if (m_iss_we) begin
                    ref_mem[m_iss_addr] = m_iss_wd;
                    m_pend_data = 4'h0;
                    m_pend_cyc  = cyc + 2;
                    m_free      = cyc + 3;
                end else begin
                    m_pend_data = ref_mem[m_iss_addr];
                    m_pend_cyc  = cyc + 3;
                    m_free      = cyc + 4;
                end
            end
            chk("m_ready", bus.req_ready, e_ready);
            chk("m_rsp_valid", bus.rsp_valid, e_rspv);
            chk("m_rsp_rdata", bus.rsp_rdata, e_rd);
            chk("m_busy", busy, !m_idle);
            chk("m_clear", mem_clear, 0);
        end
        m_prev_rst = reset;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_port(input int p, input bit v, input bit w, input logic [3:0] a, input logic [3:0] d);
        bus.req_valid[p] = v;
        bus.req_we[p]    = w;
        bus.req_addr[p]  = a;
        bus.req_wdata[p] = d;
    endtask

    // Call at posedge+1; checks the INIT cycle that follows release.
    task automatic release_reset();
        reset = 1'b1;
        @(negedge clk);
        chk("init_mem_clear", mem_clear, 1);
        chk("init_busy", busy, 1);
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        release_reset();
    endtask

    // Single request from one port; checks handshake, latency and response data.
    task automatic do_req(input int p, input bit w, input logic [3:0] a, input logic [3:0] d,
                          input logic [3:0] exp);
        int  n;
        int  lat;
        bit  got;
        @(posedge clk); #1;
        drive_port(p, 1'b1, w, a, d);
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (bus.req_ready[p]) got = 1'b1; else n++;
        end
        chk("req_handshake", got, 1);
        @(posedge clk); #1;
        drive_port(p, 1'b0, 1'b0, 4'h0, 4'h0);
        lat = 1; got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            if (bus.rsp_valid[p]) got = 1'b1; else lat++;
        end
        chk("req_latency", lat, w ? 2 : 3);
        chk("req_rdata", bus.rsp_rdata[p], exp);
    endtask

    typedef struct {
        int         port;
        bit         we;
        logic [3:0] addr;
        logic [3:0] wdata;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [10];
    int   grants [$];
    bit [1:0] acc;

    initial begin
        vecs[0] = '{0, 1'b1, 4'hF, 4'hF, 4'h0};
        vecs[1] = '{0, 1'b0, 4'hF, 4'h0, 4'hF};
        vecs[2] = '{0, 1'b0, 4'h0, 4'h0, 4'h0};
        vecs[3] = '{1, 1'b1, 4'h0, 4'h5, 4'h0};
        vecs[4] = '{1, 1'b0, 4'h0, 4'h0, 4'h5};
        vecs[5] = '{0, 1'b0, 4'hF, 4'h0, 4'hF};
        vecs[6] = '{1, 1'b1, 4'hF, 4'h2, 4'h0};
        vecs[7] = '{0, 1'b0, 4'hF, 4'h0, 4'h2};
        vecs[8] = '{1, 1'b0, 4'h3, 4'h0, 4'hA};
        vecs[9] = '{1, 1'b0, 4'h1, 4'h0, 4'h0};

        reset = 1'b1;
        bus.req_valid = 2'b00; bus.req_we = 2'b00; bus.req_addr = '0; bus.req_wdata = '0;
        #2 reset = 1'b0;

        // Reset release with a CPU write already waiting.
        drive_port(0, 1'b1, 1'b1, 4'h3, 4'hA);
        repeat (3) @(posedge clk);
        #1;
        release_reset();
        chk("init_no_ready", bus.req_ready[0], 0);
        @(negedge clk);
        chk("first_ready0", bus.req_ready[0], 1);
        chk("first_clear_low", mem_clear, 0);
        chk("first_busy_low", busy, 0);
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, 4'h0, 4'h0);
        @(negedge clk);
        chk("wr_we_t1", mem_write_enable, 1);
        chk("wr_addr_t1", mem_address, 4'h3);
        chk("wr_data_t1", mem_write_data, 4'hA);
        @(negedge clk);
        chk("wr_we_t2", mem_write_enable, 0);
        chk("wr_rsp_t2", bus.rsp_valid, 2'b01);
        chk("wr_rdata_t2", bus.rsp_rdata[0], 0);
        do_req(0, 1'b0, 4'h3, 4'h0, 4'hA);

        for (int i = 0; i < 10; i++)
            do_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

        // Simultaneous P0 read / P1 write to address 5 right after reset.
        apply_reset(2);
        @(posedge clk); #1;
        drive_port(0, 1'b1, 1'b0, 4'h5, 4'h0);
        drive_port(1, 1'b1, 1'b1, 4'h5, 4'h7);
        @(negedge clk);
        chk("sim_first_grant", bus.req_ready, 2'b01);
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, 4'h0, 4'h0);
        repeat (3) @(negedge clk);
        chk("sim_p0_rsp", bus.rsp_valid, 2'b01);
        chk("sim_p0_rdata", bus.rsp_rdata[0], 4'h0);
        chk("sim_resp_no_ready", bus.req_ready, 2'b00);
        @(negedge clk);
        chk("sim_second_grant", bus.req_ready, 2'b10);
        @(posedge clk); #1;
        drive_port(1, 1'b0, 1'b0, 4'h0, 4'h0);
        @(negedge clk);
        chk("sim_p1_we", {mem_write_enable, mem_read_enable}, 2'b10);
        chk("sim_p1_wdata", mem_write_data, 4'h7);
        @(negedge clk);
        chk("sim_p1_rsp", bus.rsp_valid, 2'b10);
        chk("sim_p1_rdata", bus.rsp_rdata[1], 4'h0);

        // Both ports continuously reading: strict alternation, never dual grant/strobe.
        @(posedge clk); #1;
        drive_port(0, 1'b1, 1'b0, 4'h1, 4'h0);
        drive_port(1, 1'b1, 1'b0, 4'h2, 4'h0);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (bus.req_valid[0] && bus.req_ready[0]) grants.push_back(0);
            if (bus.req_valid[1] && bus.req_ready[1]) grants.push_back(1);
            chk("rr_dual_ready", bus.req_ready == 2'b11, 0);
            chk("rr_dual_strobe", mem_write_enable && mem_read_enable, 0);
        end
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, 4'h0, 4'h0);
        drive_port(1, 1'b0, 1'b0, 4'h0, 4'h0);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k < grants.size()) chk("rr_grant_order", grants[k], k % 2);
            else chk("rr_grant_missing", k, grants.size());
        end
        do_req(0, 1'b0, 4'h5, 4'h0, 4'h7);

        // Reset asserted while a read is in WAIT.
        @(posedge clk); #1;
        drive_port(0, 1'b1, 1'b0, 4'h5, 4'h0);
        @(negedge clk);
        chk("rw_handshake", bus.req_ready[0], 1);
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, 4'h0, 4'h0);
        @(posedge clk); #1;
        chk("rw_busy_in_wait", busy, 1);
        reset = 1'b0;
        #1;
        chk("rw_rsp_valid", bus.rsp_valid, 0);
        chk("rw_flags", {mem_write_enable, mem_read_enable, mem_clear, busy}, 0);
        chk("rw_mem_addr", mem_address, 0);
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        do_req(0, 1'b0, 4'h5, 4'h0, 4'h0);

        // Randomized two-port traffic with a reset in the middle.
        acc = 2'b00;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (c == 300) reset = 1'b0;
            if (c == 303) reset = 1'b1;
            for (int p = 0; p < 2; p++) begin
                if (!bus.req_valid[p] || acc[p]) begin
                    drive_port(p, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.req_valid[p] = 1'b0;
                end
            end
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
        end
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, 4'h0, 4'h0);
        drive_port(1, 1'b0, 1'b0, 4'h0, 4'h0);
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "time limit");
    end

endmodule
